instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the instruction decode stage: takes decoded fields (op, register addresses, immediate) and packs them into a 32-bit RV32I instruction word.
- Encoded words are buffered in a small FIFO and drained into instruction memory through a valid/ready interface.
- Each drained word comes with a word-aligned store address, so test benches and the program loader can build imem contents from field-level descriptions.

Parameters:
- DEPTH, 4, number of FIFO entries (power of two, 2..16).
- BASE_ADDR, 32'h0000_0000, imem address of the first drained word.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  field set present.
- in_ready  out  1  encoder can accept; equals (count < DEPTH).
- op  in  14  packed opcode/function field. Format is {opcode[6:0], funct7} for R-type and {opcode[6:0], 4'b0000, funct3} otherwise. funct3 sits in op[2:0]; op[6:3] are ignored for non-R types.
- funct3_r  in  3  funct3 for R-type only, since op carries funct7 for R-type.
- addr_a  in  5  rs1.
- addr_b  in  5  rs2.
- addr_d  in  5  rd.
- immed  in  32  sign-extended immediate.
- ir  out  32  encoded instruction at the FIFO head.
- ir_valid  out  1  FIFO not empty.
- ir_ready  in  1  consumer accepts ir this cycle.
- ir_addr  out  32  imem byte address for the head word.
- err  out  1  one-cycle pulse when an accepted field set is rejected.
- count  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, immediate): FIFO empty, count=0, ir_valid=0, ir=0, ir_addr=BASE_ADDR, err=0, in_ready=1.
- Accept: a field set is accepted when in_valid&&in_ready on a rising clk edge. It is encoded combinationally and written into the FIFO on that same edge.
- Latency: the word is visible at ir/ir_valid on the next cycle when the FIFO was empty. Zero bubbles under continuous flow.
- Drain: a word is popped when ir_valid&&ir_ready. On each pop, ir_addr advances by 4 (mod 2^32). ir_addr only changes on a pop.
- Simultaneous push and pop: count is unchanged and both succeed. When full, in_ready=0, so no push occurs even if a pop happens in the same cycle (in_ready is registered from count, with no pass-through).
- Pointers wrap modulo DEPTH. count saturates logically at DEPTH, which is guaranteed by in_ready.
- Stability: ir and ir_addr must hold while ir_valid&&!ir_ready.
- Encoding by opcode = op[13:7]; in every format ir[6:0]=opcode:
  - R 0110011: {op[6:0], addr_b, addr_a, funct3_r, addr_d, opcode}.
  - I1 0000011 and I2 0010011: {immed[11:0], addr_a, op[2:0], addr_d, opcode}.
  - S 0100011: {immed[11:5], addr_b, addr_a, op[2:0], immed[4:0], opcode}.
  - B 1100011: {immed[12], immed[10:5], addr_b, addr_a, op[2:0], immed[4:1], immed[11], opcode}.
  - J 1101111: {immed[20], immed[10:1], immed[11], immed[19:12], addr_d, opcode}.
- Any other opcode: the set is accepted (handshake completes), not written to the FIFO, and err pulses for 1 cycle.
- B/J with immed[0]=1: the set is rejected with err (misaligned target).
- Reset asserted mid-stream: all buffered words are discarded and ir_addr returns to BASE_ADDR. No partial word is ever presented.

Optional Feature:
- Macro: ENCODER_RANGE_CHECK_EN.
- Defined: immed must be representable in the format's signed field width (I/S 12b, B 13b, J 21b). If it is not, the set is rejected with an err pulse and nothing is written.
- Undefined: immediates are silently truncated to the field bits listed above. err is raised only for unknown opcode or misaligned B/J.

Test Plan:
- After reset, push R-type op={0110011,0000000}, funct3_r=0, a=2, b=3, d=1 with ir_ready=1 → next cycle ir=32'h003100B3, ir_addr=0; following cycle ir_valid=0.
- Push I2 addi op={0010011,0000000}, a=0, d=5, immed=-1 → ir=32'hFFF00293. Push S sw op={0100011,4'b0,010}, a=2, b=5, immed=8 → ir=32'h00512423; ir_addr goes 0 then 4.
- Hold ir_ready=0 and push 5 sets with DEPTH=4 → in_ready=0 after the 4th, count=4, 5th not accepted. Release ir_ready → 4 words in order, addresses 0,4,8,12, then the 5th.
- Push opcode 7'b1111111 → err=1 for exactly one cycle, count unchanged. Push B with immed=3 → err pulse.
- Push B beq op={1100011,0000000}, a=1, b=2, immed=-4 → ir=32'hFE208EE3. Push J jal d=1, immed=2048 → ir=32'h001000EF.
- Assert reset with 3 words buffered → ir_valid=0, count=0, ir_addr=BASE_ADDR at once. With ENCODER_RANGE_CHECK_EN, I immed=4096 → err; without it, ir[31:20]=0.

Source files
------------

// File: rtl/instr_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder_if
// Description : Bundle of handshake and data signals around instr_encoder.
//               Upstream side carries decoded fields (op, addr_a/b/d, immed)
//               with in_valid/in_ready. Downstream side carries the encoded
//               word (ir), its imem byte address (ir_addr), and
//               ir_valid/ir_ready. It also carries the err pulse and the FIFO
//               occupancy (count).
//               Modports:
//                 master : producer/consumer side (drives fields, ir_ready)
//                 slave  : encoder side (drives in_ready, ir*, err, count)
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_encoder_if #(
  parameter int DEPTH = 4
);
  localparam int c_CW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [13:0]     op;
  logic [2:0]      funct3_r;
  logic [4:0]      addr_a;
  logic [4:0]      addr_b;
  logic [4:0]      addr_d;
  logic [31:0]     immed;
  logic [31:0]     ir;
  logic            ir_valid;
  logic            ir_ready;
  logic [31:0]     ir_addr;
  logic            err;
  logic [c_CW-1:0] count;

  modport master (
    output in_valid, op, funct3_r, addr_a, addr_b, addr_d, immed, ir_ready,
    input  in_ready, ir, ir_valid, ir_addr, err, count
  );

  modport slave (
    input  in_valid, op, funct3_r, addr_a, addr_b, addr_d, immed, ir_ready,
    output in_ready, ir, ir_valid, ir_addr, err, count
  );
endinterface
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Packs decoded RV32I fields into 32-bit instruction words.
//               Buffers them in a DEPTH-entry FIFO and presents each head word
//               with its word-aligned imem byte address.
//               Ports:
//                 clk   - system clock
//                 reset - asynchronous, active-high reset
//                 bus   - instr_encoder_if.slave:
//                           fields in (in_valid/in_ready),
//                           words out (ir/ir_valid/ir_ready/ir_addr),
//                           err pulse, count occupancy
//               Optional feature macro: ENCODER_RANGE_CHECK_EN
//                 defined   : immediates that do not fit the format's signed
//                             field width are rejected with err
//                 undefined : immediates are silently truncated
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  instr_encoder_if.slave bus
);

  localparam int              c_PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              c_CW   = $clog2(DEPTH) + 1;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  logic [31:0]     r_mem [DEPTH];
  logic [c_PW-1:0] r_wr_ptr;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;
  logic [31:0]     r_addr;
  logic            r_err;

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [31:0] w_imm;
  logic [31:0] w_word;
  logic        w_ok;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_push;
  logic        w_pop;
  logic        w_fit_12;
  logic        w_fit_13;
  logic        w_fit_21;
  logic        w_unused_imm;

  assign w_opc = bus.op[13:7];
  assign w_f3  = bus.op[2:0];
  assign w_imm = bus.immed;

  // Upper immediate bits only matter when range checking is enabled.
  assign w_unused_imm = ^w_imm[31:21];

`ifdef ENCODER_RANGE_CHECK_EN
  // A value fits an N-bit signed field when bits [31:N-1] are all equal.
  assign w_fit_12 = (&w_imm[31:11]) | ~(|w_imm[31:11]);
  assign w_fit_13 = (&w_imm[31:12]) | ~(|w_imm[31:12]);
  assign w_fit_21 = (&w_imm[31:20]) | ~(|w_imm[31:20]);
`else
  assign w_fit_12 = 1'b1;
  assign w_fit_13 = 1'b1;
  assign w_fit_21 = 1'b1;
`endif

  // Field packing. w_ok low means the set is consumed but dropped with err.
  always_comb begin
    w_word = '0;
    w_ok   = 1'b0;
    case (w_opc)
      c_OP_R: begin
        w_word = {bus.op[6:0], bus.addr_b, bus.addr_a, bus.funct3_r,
                  bus.addr_d, w_opc};
        w_ok   = 1'b1;
      end
      c_OP_LOAD, c_OP_IMM: begin
        w_word = {w_imm[11:0], bus.addr_a, w_f3, bus.addr_d, w_opc};
        w_ok   = w_fit_12;
      end
      c_OP_STORE: begin
        w_word = {w_imm[11:5], bus.addr_b, bus.addr_a, w_f3, w_imm[4:0], w_opc};
        w_ok   = w_fit_12;
      end
      c_OP_BRANCH: begin
        w_word = {w_imm[12], w_imm[10:5], bus.addr_b, bus.addr_a, w_f3,
                  w_imm[4:1], w_imm[11], w_opc};
        w_ok   = ~w_imm[0] & w_fit_13;
      end
      c_OP_JAL: begin
        w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                  bus.addr_d, w_opc};
        w_ok   = ~w_imm[0] & w_fit_21;
      end
      default: begin
        w_word = '0;
        w_ok   = 1'b0;
      end
    endcase
  end

  // in_ready depends only on registered occupancy, so a same-cycle pop never
  // opens a slot for a push when the FIFO is full.
  assign w_in_ready = (r_count != c_FULL);
  assign w_accept   = bus.in_valid & w_in_ready;
  assign w_push     = w_accept & w_ok;
  assign w_pop      = (r_count != '0) & bus.ir_ready;

  // Storage has no reset; visibility is gated by r_count below.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_addr   <= BASE_ADDR;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_accept & ~w_ok;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
        r_addr   <= r_addr + 32'd4;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.ir_valid = (r_count != '0);
  // Force zero when empty so stale storage is never shown.
  assign bus.ir       = (r_count != '0) ? r_mem[r_rd_ptr] : 32'h0;
  assign bus.ir_addr  = r_addr;
  assign bus.err      = r_err;
  assign bus.count    = r_count;

endmodule
`default_nettype wire
